ser_step_dir_n: RTL
===================

Name: ser_step_dir_n

Overview:
Multi-channel stepper phase generator with an integrated serialiser.
- Converts N_CH single-cycle step/dir commands into per-channel Johnson-counter phase patterns.
- Ships the concatenated phase word to the external motor shift-register chain over sclk/sdo/lock.
- Successor to the fixed 4-channel 5/3-phase version, adding:
  - a uniform parametrised phase width;
  - output enable;
  - periodic refresh;
  - per-channel sticky overrun flags.

Parameters:
- N_CH, 4, number of motor channels (1..8).
- PHASE_W, 5, phase bits per channel; Johnson counter with 2*PHASE_W states (2..8).
- CLK_DIV, 10, clk cycles per sclk half-period (>=2).
- REFRESH, 100000, clk cycles of idle after which the current frame is re-sent; 0 disables refresh.

Ports:
- clk  in  1  system clock
- sclr_n  in  1  synchronous reset, active low
- step  in  N_CH  one-cycle step pulse per channel
- dir  in  N_CH  direction per channel; 1 = forward; sampled together with step
- en  in  1  output enable; 0 forces all-zero frames
- clr_ovr  in  1  clears all overrun flags
- mtr_sclk  out  1  serial clock, idles low
- mtr_sdo  out  1  serial data, MSB first
- mtr_lock  out  1  latch pulse after the last bit
- busy  out  1  frame in progress
- overrun  out  N_CH  sticky: channel stepped more than once within one frame interval

Behaviour:
- Reset (sclr_n=0 at a clk edge) clears the following:
  - all phases to 0;
  - mtr_sclk, mtr_sdo, mtr_lock, busy, overrun, pending, refresh counter.
  - An in-flight frame is aborted immediately; no partial lock is issued.
- Phase update, per channel, same cycle as step=1:
  - forward: ph <= {ph[W-2:0], ~ph[W-1]};
  - reverse: ph <= {~ph[0], ph[W-1:1]}.
  - Forward sequence for W=5: 00000, 00001, 00011, 00111, 01111, 11111, 11110, ..., 10000, then 00000 (wrap).
- pending[ch] is set on any step of ch. It is cleared when a frame load samples that channel.
- overrun[ch] is set when step[ch]=1 while pending[ch] is already 1 (a pattern the driver never saw).
  - If clr_ovr and a new overrun event occur in the same cycle, set wins.
- Frame word:
  - en=1: {ph[N_CH-1], ..., ph[0]}, N_CH*PHASE_W bits.
  - en=0: all zeros.
- A toggle of en counts as a change and sets a global pending.
- Load condition, evaluated when the FSM is in IDLE:
  - any pending, or
  - refresh counter reached REFRESH.
- Load captures the word into the shift register and clears the sampled pendings.
  - A step arriving in the load cycle is not in the frame; it sets pending for the next frame.
- FSM:
  - IDLE: busy=0, sclk=0, lock=0. On load -> SHIFT, with busy=1 on the next cycle.
  - SHIFT:
    - For each bit, sdo is driven from shift MSB, held CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
    - The register shifts on the sclk falling edge.
    - After bit count N_CH*PHASE_W -> LOCK.
  - LOCK: sdo=0, sclk=0, lock=1 for CLK_DIV cycles -> GAP.
  - GAP: lock=0 for CLK_DIV cycles -> IDLE. busy drops on entry to IDLE.
- Frame length in clk cycles: 2*CLK_DIV*N_CH*PHASE_W + 2*CLK_DIV. This equals 420 for the default parameters.
- Refresh counter:
  - counts clk cycles only in IDLE;
  - clears on every load;
  - saturates at REFRESH.
- Steps during busy are never lost from the phase state. Only intermediate patterns may be skipped, and each skip is flagged by overrun.

Decomposition:
- Package ser_step_dir_pkg holds:
  - the FSM state enum (IDLE, SHIFT, LOCK, GAP);
  - the function johnson_next(ph, dir);
  - the frame-length localparam.
- Natural sub-module: ser_frame_tx.
  - It contains the serialiser FSM and the bit/divider counters.
  - Its interface is data, wrreq, busy, sclk, sdo, lock.
  - Channel logic and the refresh/pending logic stay in the top.

Test Plan:
- Reset, then a single forward step on ch0 (N_CH=4, W=5) -> one frame of 20 bits, with ch0 field 00001 and all others 0. Lock pulse is 10 clk wide; busy is high for 420 clk.
- Five forward steps then six reverse steps on ch2, each after busy falls -> ch2 sequence 00001..11111, then back down, wrapping to 10000. No overrun.
- Three ch1 steps inside one busy window -> exactly one follow-up frame carrying the 3-step phase 00111. overrun=0010 stays set until clr_ovr; clr_ovr together with a new overrun event leaves the bit set.
- en 1->0 with nonzero phases -> an all-zero frame is sent. en 0->1 -> a frame with the preserved phases is sent.
- REFRESH=1000, no steps -> a frame restarts exactly 1000 idle cycles after each busy fall, with identical content.
- sclr_n low mid-SHIFT -> next cycle sclk=sdo=lock=busy=0 and phases=0. No lock pulse is emitted for the aborted frame.

Source files
------------

// File: rtl/ser_step_dir_pkg.sv
// ser_step_dir_pkg: shared definitions for the stepper phase generator.
//   tx_state_e     - serialiser FSM states
//   johnson_next() - one Johnson-counter step of a phase field (up to 8 bits)
//   frame_len()    - clk cycles occupied by one frame (busy high time)
package ser_step_dir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOCK  = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  // Widest phase field supported by johnson_next.
  localparam int unsigned PH_MAX_W = 8;

  // Busy time of one frame: two sclk half-periods per bit, plus lock and gap.
  function automatic int unsigned frame_len(input int unsigned n_ch,
                                            input int unsigned w,
                                            input int unsigned div);
    return 2 * div * n_ch * w + 2 * div;
  endfunction

  // Frame length for the default build (4 channels x 5 bits, CLK_DIV=10): 420.
  localparam int unsigned FRAME_LEN_DEFAULT = frame_len(4, 5, 10);

  // Johnson step on the low w bits of ph; bits at and above w come back zero.
  // dir=1: {ph[w-2:0], ~ph[w-1]}   dir=0: {~ph[0], ph[w-1:1]}
  function automatic logic [PH_MAX_W-1:0] johnson_next(input logic [PH_MAX_W-1:0] ph,
                                                       input logic                dir,
                                                       input int unsigned         w);
    logic [2:0]          msb;
    logic [PH_MAX_W-1:0] mask;
    logic [PH_MAX_W-1:0] nxt;
    msb  = 3'(w - 1);
    mask = PH_MAX_W'((16'd1 << w) - 16'd1);
    if (dir) begin
      nxt      = {ph[PH_MAX_W-2:0], 1'b0};
      nxt[0]   = ~ph[msb];
    end else begin
      nxt      = {1'b0, ph[PH_MAX_W-1:1]};
      nxt[msb] = ~ph[0];
    end
    return nxt & mask;
  endfunction

endpackage

// File: rtl/ser_frame_tx.sv
// ser_frame_tx: serialises one DATA_W-bit word to a shift-register chain.
//   clk, sclr_n  clock, synchronous active-low reset
//   data_i       word to send (captured when wrreq_i is accepted)
//   wrreq_i      load request, accepted only while idle
//   busy_o       high from the cycle after the load until the frame ends
//   sclk_o       serial clock, idles low, CLK_DIV cycles per half-period
//   sdo_o        serial data, MSB first, changes while sclk is low
//   lock_o       latch pulse, CLK_DIV cycles, after the last bit
// All outputs are registered so the off-chip lines never glitch.
module ser_frame_tx
  import ser_step_dir_pkg::*;
#(
  parameter int unsigned DATA_W  = 20,
  parameter int unsigned CLK_DIV = 10
) (
  input  logic              clk,
  input  logic              sclr_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wrreq_i,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              sdo_o,
  output logic              lock_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              half_q, half_d;   // 0: sclk low half, 1: sclk high half
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              busy_q, sclk_q, sdo_q, lock_q;
  logic              div_end;

  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wrreq_i) begin
          state_d = ST_SHIFT;
          shift_d = data_i;
          div_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            // sclk falling edge: advance to the next bit
            half_d  = 1'b0;
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            if (bit_q == BIT_LAST) state_d = ST_LOCK;
            else                   bit_d   = bit_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_LOCK: begin
        if (div_end) begin
          div_d   = '0;
          state_d = ST_GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (div_end) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      // outputs follow the next state so they line up with it
      busy_q  <= (state_d != ST_IDLE);
      sclk_q  <= (state_d == ST_SHIFT) && half_d;
      sdo_q   <= (state_d == ST_SHIFT) && shift_d[DATA_W-1];
      lock_q  <= (state_d == ST_LOCK);
    end
  end

  assign busy_o = busy_q;
  assign sclk_o = sclk_q;
  assign sdo_o  = sdo_q;
  assign lock_o = lock_q;

endmodule

// File: rtl/ser_step_dir_n.sv
// ser_step_dir_n: N_CH-channel stepper phase generator with serial output.
//   clk, sclr_n   clock, synchronous active-low reset
//   step[N_CH]    one-cycle step pulse per channel
//   dir[N_CH]     direction per channel, 1 = forward, sampled with step
//   en            output enable, 0 sends all-zero frames
//   clr_ovr       clears all overrun flags (a same-cycle new event wins)
//   mtr_sclk/mtr_sdo/mtr_lock  serial link to the motor shift registers
//   busy          frame in progress
//   overrun[N_CH] sticky: channel stepped again before its pattern was sent
module ser_step_dir_n
  import ser_step_dir_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned PHASE_W = 5,
  parameter int unsigned CLK_DIV = 10,
  parameter int unsigned REFRESH = 100000
) (
  input  logic            clk,
  input  logic            sclr_n,
  input  logic [N_CH-1:0] step,
  input  logic [N_CH-1:0] dir,
  input  logic            en,
  input  logic            clr_ovr,
  output logic            mtr_sclk,
  output logic            mtr_sdo,
  output logic            mtr_lock,
  output logic            busy,
  output logic [N_CH-1:0] overrun
);

  localparam int unsigned WORD_W = N_CH * PHASE_W;

  logic [WORD_W-1:0] ph_word;
  logic [WORD_W-1:0] frame_word;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [N_CH-1:0]   ovr_q, ovr_d;
  logic              gpend_q, gpend_d;
  logic              en_q;
  logic              tx_busy;
  logic              load;
  logic              refresh_due;

  // Per-channel phase register; ch0 lands in the least significant field.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [PHASE_W-1:0] ph_q;
      always_ff @(posedge clk) begin
        if (!sclr_n)       ph_q <= '0;
        else if (step[gi]) ph_q <= PHASE_W'(johnson_next(PH_MAX_W'(ph_q), dir[gi], PHASE_W));
      end
      assign ph_word[gi*PHASE_W +: PHASE_W] = ph_q;
    end
  endgenerate

  assign frame_word = en ? ph_word : '0;
  // The serialiser's registered busy is low exactly when its FSM is idle.
  assign load = !tx_busy && ((|pend_q) || gpend_q || refresh_due);

  always_comb begin
    // A step in the load cycle is not in this frame, so it re-arms pending.
    pend_d  = (pend_q & ~{N_CH{load}}) | step;
    // The pattern being overwritten was never shipped unless this is a load cycle.
    ovr_d   = (ovr_q & ~{N_CH{clr_ovr}}) | (step & pend_q & ~{N_CH{load}});
    gpend_d = (gpend_q & ~load) | (en ^ en_q);
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      pend_q  <= '0;
      ovr_q   <= '0;
      gpend_q <= 1'b0;
      en_q    <= en;   // no spurious enable-change frame after reset
    end else begin
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      gpend_q <= gpend_d;
      en_q    <= en;
    end
  end

  // Idle-time counter: re-sends the current frame after REFRESH idle cycles.
  generate
    if (REFRESH > 0) begin : g_refresh
      localparam int unsigned RC_W = $clog2(REFRESH + 1);
      localparam logic [RC_W-1:0] RC_MAX = RC_W'(REFRESH);
      logic [RC_W-1:0] rcnt_q, rcnt_d;
      always_comb begin
        rcnt_d = rcnt_q;
        if (load)                             rcnt_d = '0;
        else if (!tx_busy && rcnt_q != RC_MAX) rcnt_d = rcnt_q + RC_W'(1);
      end
      always_ff @(posedge clk) begin
        if (!sclr_n) rcnt_q <= '0;
        else         rcnt_q <= rcnt_d;
      end
      assign refresh_due = (rcnt_q == RC_MAX);
    end else begin : g_no_refresh
      assign refresh_due = 1'b0;
    end
  endgenerate

  ser_frame_tx #(
    .DATA_W  (WORD_W),
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk     (clk),
    .sclr_n  (sclr_n),
    .data_i  (frame_word),
    .wrreq_i (load),
    .busy_o  (tx_busy),
    .sclk_o  (mtr_sclk),
    .sdo_o   (mtr_sdo),
    .lock_o  (mtr_lock)
  );

  assign busy    = tx_busy;
  assign overrun = ovr_q;

endmodule
